// File: rtl/oled_spi_rx.sv
`timescale 1ns/1ps
// oled_spi_rx
//   Passive receiver for a write-only OLED SPI link. SCL/SDA/DC/RES are
//   sampled in the clk domain. Completed bytes are queued, together with
//   their DC flag, in a small FIFO with a valid/ready read port.
//
// Ports
//   clk          single clock for all logic
//   rst          asynchronous active-high reset
//   scl_in       serial clock from the panel connector (async)
//   sda_in       serial data, MSB first (async)
//   dc_in        data/command select, 1 = data (async)
//   res_n_in     display reset, active-low (async); also flushes this block
//   rx_data      byte at FIFO head (0 while empty)
//   rx_dc        DC flag of the head byte (0 while empty)
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts the head entry
//   fifo_level   occupied entries
//   overflow     sticky, a completed byte was dropped on a full FIFO
//   ovf_clr      clears overflow (a drop in the same cycle wins)
//   frame_err    one-cycle pulse when a partial byte times out
module oled_spi_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       dc_in,
  input  logic       res_n_in,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [4:0] fifo_level,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       frame_err
);

  localparam int DATA_W = 8;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [4:0]    LVL_FULL = 5'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1;
  logic dc_p0, dc_p1;
  logic res_n_p0, res_n_p1;

  logic [2:0]        bit_cnt;
  logic [TW-1:0]     to_cnt;
  logic [DATA_W-1:0] shreg;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W:0]   head;

  logic rise, push, full, pop, wr_en, drop, timeout_hit;
  logic [DATA_W:0] push_word;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous SCL for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p0   <= 1'b0;
      scl_p1   <= 1'b0;
      scl_p2   <= 1'b0;
      sda_p0   <= 1'b0;
      sda_p1   <= 1'b0;
      dc_p0    <= 1'b0;
      dc_p1    <= 1'b0;
      res_n_p0 <= 1'b0;
      res_n_p1 <= 1'b0;
    end else begin
      scl_p0   <= scl_in;
      scl_p1   <= scl_p0;
      scl_p2   <= scl_p1;
      sda_p0   <= sda_in;
      sda_p1   <= sda_p0;
      dc_p0    <= dc_in;
      dc_p1    <= dc_p0;
      res_n_p0 <= res_n_in;
      res_n_p1 <= res_n_p0;
    end
  end

  assign rise        = scl_p1 & ~scl_p2 & res_n_p1;
  assign push        = rise & (bit_cnt == 3'd7);
  assign push_word   = {dc_p1, shreg[DATA_W-2:0], sda_p1};
  assign full        = (fifo_level == LVL_FULL);
  assign pop         = rx_valid & rx_ready;
  assign wr_en       = push & (~full | pop);
  assign drop        = push & full & ~pop;
  assign timeout_hit = ~rise & (bit_cnt != 3'd0) & (to_cnt == TO_LAST);

  // Stage p3: bit assembly and idle timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else if (!res_n_p1) begin
      bit_cnt   <= 3'd0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout_hit;
      if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        to_cnt  <= '0;
      end else if (bit_cnt != 3'd0) begin
        if (timeout_hit) begin
          bit_cnt <= 3'd0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n_p1) shreg <= '0;
    else if (rise) shreg <= {shreg[DATA_W-2:0], sda_p1};
  end

  // Stage p3: FIFO storage, pointers and status
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 5'd0;
      overflow   <= 1'b0;
    end else if (!res_n_p1) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 5'd0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Head outputs are gated so that an empty or reset FIFO reads as zero
  assign head     = mem[rd_ptr];
  assign rx_valid = (fifo_level != 5'd0);
  assign rx_data  = rx_valid ? head[DATA_W-1:0] : '0;
  assign rx_dc    = rx_valid ? head[DATA_W] : 1'b0;

endmodule

// File: tb/tb_oled_spi_rx.sv
`timescale 1ns/1ps
// tb_oled_spi_rx
//   Self-checking bench for oled_spi_rx: a table of bytes plus hand-written
//   sequences for latency, overflow, full-with-pop, timeout, display reset and
//   mid-byte reset. Expected {dc,byte} words are queued when sent and compared
//   whenever the DUT hands a word to the consumer.
module tb_oled_spi_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in, sda_in, dc_in, res_n_in;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, rx_ready;
  logic [4:0] fifo_level;
  logic       overflow, ovf_clr, frame_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] sb[$];

  typedef struct {
    logic [7:0] tx;
    logic       tx_dc;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl [5];

  oled_spi_rx #(.FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .dc_in(dc_in),
    .res_n_in(res_n_in), .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_level(fifo_level), .overflow(overflow),
    .ovf_clr(ovf_clr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Observes the read port on the falling edge; a pop happens on the next rising edge
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: actual=0x%0h required=no word", {rx_dc, rx_data});
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          check("rx_word", 32'({rx_dc, rx_data}), 32'(e));
        end
      end
    end
  endtask

  // Sends the top n bits of d, MSB first; SCL is left high after the last bit
  task automatic send_bits(input logic [7:0] d, input logic dc, input int n);
    dc_in = dc;
    for (int i = 7; i > 7 - n; i--) begin
      sda_in = d[i];
      scl_in = 1'b0;
      repeat (3) tick();
      scl_in = 1'b1;
      repeat (3) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic dc);
    send_bits(d, dc, 8);
    scl_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain(input string name);
    rx_ready = 1'b1;
    for (int i = 0; i < 64 && fifo_level != 5'd0; i++) tick();
    rx_ready = 1'b0;
    check(name, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe;
    tbl[0] = '{tx: 8'h5A, tx_dc: 1'b1, exp: 9'h15A};
    tbl[1] = '{tx: 8'h00, tx_dc: 1'b1, exp: 9'h100};
    tbl[2] = '{tx: 8'hFF, tx_dc: 1'b0, exp: 9'h0FF};
    tbl[3] = '{tx: 8'h81, tx_dc: 1'b1, exp: 9'h181};
    tbl[4] = '{tx: 8'h3C, tx_dc: 1'b0, exp: 9'h03C};

    rst = 1'b1; scl_in = 1'b0; sda_in = 1'b0; dc_in = 1'b0; res_n_in = 1'b1;
    rx_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    check("rst_valid",    32'(rx_valid),   32'd0);
    check("rst_data",     32'(rx_data),    32'd0);
    check("rst_dc",       32'(rx_dc),      32'd0);
    check("rst_level",    32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_frame",    32'(frame_err),  32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    fork
      monitor();
    join_none

    // Latency: 0xAE as a command, valid three edges after SCL high is first sampled
    rx_ready = 1'b1;
    sb.push_back(9'h0AE);
    send_bits(8'hAE, 1'b0, 7);
    sda_in = 1'b0;
    scl_in = 1'b0;
    repeat (3) tick();
    scl_in = 1'b1;
    tick();
    check("lat_e1", 32'(rx_valid), 32'd0);
    tick();
    check("lat_e2", 32'(rx_valid), 32'd0);
    tick();
    check("lat_e3", 32'(rx_valid), 32'd1);
    tick();
    check("lat_e4_popped", 32'(rx_valid), 32'd0);
    scl_in = 1'b0;
    repeat (3) tick();

    // Table of bytes streamed with the consumer always ready
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tbl[i].exp);
      send_byte(tbl[i].tx, tbl[i].tx_dc);
    end
    repeat (5) tick();
    check("table_all_seen", 32'(sb.size()), 32'd0);

    // Overflow: five bytes into a four-entry FIFO with no consumer
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back({1'b1, 8'(i)});
      send_byte(8'(i), 1'b1);
    end
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_hold_data", 32'(rx_data), 32'h01);
    drain("ovf_drain");
    check("ovf_drain_sb", 32'(sb.size()), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO: fifth byte lands in the same cycle as a pop
    for (int i = 1; i <= 5; i++) sb.push_back({1'b1, 8'(i)});
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    send_bits(8'h05, 1'b1, 7);
    sda_in = 1'b1;
    scl_in = 1'b0;
    repeat (3) tick();
    scl_in = 1'b1;
    tick();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("fullpop_level", 32'(fifo_level), 32'd4);
    check("fullpop_ovf",   32'(overflow),   32'd0);
    scl_in = 1'b0;
    repeat (3) tick();
    drain("fullpop_drain");
    check("fullpop_sb", 32'(sb.size()), 32'd0);

    // Timeout: three bits then a long idle SCL
    rx_ready = 1'b1;
    send_bits(8'hE0, 1'b1, 3);
    scl_in = 1'b0;
    fe = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (frame_err) fe++;
    end
    check("timeout_pulses", 32'(fe), 32'd1);
    sb.push_back(9'h15A);
    send_byte(8'h5A, 1'b1);
    repeat (5) tick();
    check("timeout_recover", 32'(sb.size()), 32'd0);

    // Display reset: two entries plus sticky overflow are flushed
    rx_ready = 1'b0;
    sb.push_back(9'h111);
    sb.push_back(9'h112);
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 1'b1);
    rx_ready = 1'b1;
    tick();
    tick();
    rx_ready = 1'b0;
    check("resn_pre_level", 32'(fifo_level), 32'd2);
    check("resn_pre_ovf",   32'(overflow),   32'd1);
    res_n_in = 1'b0;
    repeat (4) tick();
    res_n_in = 1'b1;
    repeat (3) tick();
    check("resn_level", 32'(fifo_level), 32'd0);
    check("resn_ovf",   32'(overflow),   32'd0);
    check("resn_valid", 32'(rx_valid),   32'd0);
    res_n_in = 1'b0;
    send_byte(8'h77, 1'b1);
    res_n_in = 1'b1;
    repeat (4) tick();
    check("resn_scl_ignored", 32'(fifo_level), 32'd0);
    rx_ready = 1'b1;
    sb.push_back(9'h142);
    send_byte(8'h42, 1'b1);
    repeat (5) tick();
    check("resn_recover", 32'(sb.size()), 32'd0);

    // Reset in the middle of a byte
    send_bits(8'hFF, 1'b1, 5);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(rx_valid), 32'd0);
    repeat (2) tick();
    scl_in = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    sb.push_back(9'h03C);
    send_byte(8'h3C, 1'b0);
    repeat (10) tick();
    check("rst_mid_one_byte", 32'(sb.size()), 32'd0);
    check("rst_mid_empty",    32'(fifo_level), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_spi_rx.md
OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of byte entries in the receive FIFO (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 1023: clk cycles without an SCL rising edge before a partial byte is discarded.
REQ-003 Port clk  input  1: single clock for all logic.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port scl_in  input  1: serial clock from the P port (OLED_SCL); asynchronous to clk.
REQ-006 Port sda_in  input  1: serial data (OLED_SDA); asynchronous.
REQ-007 Port dc_in  input  1: data/command select (OLED_DC); 1 = data, 0 = command; asynchronous.
REQ-008 Port res_n_in  input  1: display reset (OLED_RES), active-low; asynchronous.
REQ-009 Port rx_data  output  8: received byte at FIFO head.
REQ-010 Port rx_dc  output  1: DC flag of the byte at FIFO head.
REQ-011 Port rx_valid  output  1: FIFO non-empty.
REQ-012 Port rx_ready  input  1: consumer accepts the head entry.
REQ-013 Port fifo_level  output  5: number of occupied FIFO entries.
REQ-014 Port overflow  output  1: sticky; a completed byte was dropped because the FIFO was full.
REQ-015 Port ovf_clr  input  1: synchronous clear of overflow.
REQ-016 Port frame_err  output  1: one-cycle pulse when a partial byte is discarded by timeout.

Function
REQ-017 scl_in, sda_in, dc_in and res_n_in SHALL each pass through a 2-flop synchronizer before use.
REQ-018 SCL rising edge SHALL be detected as synchronized SCL = 1 while its previous registered value = 0; falling edges are ignored.
REQ-019 On each rising edge, synchronized SDA SHALL shift into an 8-bit register, MSB first; a 3-bit counter tracks bits 0..7.
REQ-020 On the 8th rising edge, synchronized DC SHALL be sampled and {dc, byte} pushed into the FIFO; counter returns to 0.
REQ-021 Latency: rx_valid SHALL be 1 after exactly 3 clk rising edges, counting the edge that first samples the 8th SCL high, when the FIFO was empty.
REQ-022 SCL high and low phases are required to be >= 2 clk periods each; shorter phases are undefined behaviour.
REQ-023 Handshake: the head entry SHALL pop on a clk edge where rx_valid = 1 and rx_ready = 1; rx_data/rx_dc SHALL hold stable while rx_valid = 1 and rx_ready = 0.
REQ-024 Push with FIFO full and no pop SHALL drop the byte and set overflow; FIFO contents unchanged.
REQ-025 Push with FIFO full and simultaneous pop SHALL accept the byte; level stays FIFO_DEPTH; overflow unchanged.
REQ-026 Push with FIFO empty SHALL NOT bypass to outputs; data appears on the next cycle.
REQ-027 fifo_level SHALL equal pushes minus pops and never exceed FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
REQ-028 Timeout counter SHALL reset on every SCL rising edge and count only while bit counter != 0; on reaching TIMEOUT, the partial byte is discarded, the bit counter cleared, and frame_err pulses for 1 cycle.
REQ-029 Synchronized res_n_in = 0 SHALL clear the shift register, bit counter, timeout counter, FIFO (level 0) and overflow, and ignore SCL edges while low.
REQ-030 ovf_clr = 1 SHALL clear overflow on the next edge; a drop in the same cycle takes priority (overflow stays 1).

Reset
REQ-031 rst = 1 SHALL immediately force rx_valid = 0, rx_data = 0x00, rx_dc = 0, fifo_level = 0, overflow = 0, frame_err = 0, bit counter = 0, and synchronizer flops to 0 (SCL prev = 0).
REQ-032 rst asserted mid-byte SHALL discard the partial byte; after release, the first SCL rising edge is bit 7 of a new byte.

Verification
REQ-033 Send 0xAE with dc=0, rx_ready=1 -> one pop with rx_data=0xAE, rx_dc=0; rx_valid high exactly 3 edges after the 8th SCL high is sampled.
REQ-034 rx_ready=0, send 0x01,0x02,0x03,0x04,0x05 (dc=1) -> fifo_level=4, overflow=1; drain yields 0x01..0x04 in order; 0x05 is lost.
REQ-035 FIFO full, 5th byte completes in the same cycle as a pop -> no overflow, level stays 4, final drain order 0x02..0x05.
REQ-036 Send 3 bits, then SCL idle 1023 cycles -> frame_err pulses once; next 8 bits 0x5A deliver 0x5A.
REQ-037 FIFO holding 2 entries, overflow=1, pulse res_n_in low for 4 cycles -> fifo_level=0, overflow=0, rx_valid=0; SCL edges during low produce no byte.
REQ-038 Assert rst after 5 bits of 0xFF, release, send 0x3C -> exactly one byte, 0x3C, received.
